uart_peripheral: RTL and testbench

Memory-mapped UART on the same CPU data bus as the timer/LED/switch/digit peripheral, decoding its own word addresses at 0x40000018–0x40000020. Serialises a byte written by software onto uart_txd and deserialises bytes arriving on uart_rxd. A single interrupt line reports tx-complete or rx-ready. It is the bus peripheral nearest to the board pins after the LED/digit block.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 144 ++++++++++++++
 rtl/uart_peripheral.sv | 212 +++++++++++++++++++++
 tb/tb_uart_peripheral.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses,
// CON register bit positions and the state encoding used by both the
// transmit and receive state machines.
package uart_pkg;

    // Word addresses decoded with a full 32-bit compare
    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    // CON register bit positions
    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_READY   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_PARITY_ERR = 6;

    // Frame position; ST_PARITY is only visited in parity builds
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: two-flop synchroniser, start-bit qualification and
// mid-bit sampling. Build option UART_PARITY_EN adds an even-parity bit
// check between D7 and STOP.
// Output handshake: o_rx_valid is a single-cycle pulse with o_rx_byte
// stable during that cycle; there is no backpressure, the consumer must
// capture the byte on the pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    uart_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_perr;
`ifdef UART_PARITY_EN
    logic          r_par_bad;
`endif

    logic w_fall;
    logic w_cnt_last;

    assign w_fall     = r_prev & ~r_sync2;
    assign w_cnt_last = (r_cnt == BIT_LAST);

    // Bring the asynchronous line into the clock domain; reset to idle-high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Receive FSM: half-bit start check, then one sample per bit period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        r_bit <= 3'd0;
                        // Line back high at mid-start means a glitch
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ r_sync2;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        // A low stop bit is a framing error: drop silently
`ifdef UART_PARITY_EN
                        if (r_sync2) begin
                            if (r_par_bad) r_perr  <= 1'b1;
                            else           r_valid <= 1'b1;
                        end
`else
                        if (r_sync2) r_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_rx_byte    = r_shift;
    assign o_rx_valid   = r_valid;
    assign o_parity_err = r_perr;

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART on the CPU data bus: TXD/RXD/CON registers, the
// transmit FSM and the status flags feeding the level interrupt.
// Build option UART_PARITY_EN selects 8E1 framing and exposes CON bit6
// parity_err; without it frames are 8N1 and bit6 reads 0.
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irqout
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_byte;
    logic          r_txd;
    logic          r_tx_busy;
    logic          r_tx_done;
    logic          r_tx_irq_en;
    logic          r_rx_irq_en;
    logic          r_rx_ready;
    logic          r_rx_overrun;
    logic [7:0]    r_rx_data;
`ifdef UART_PARITY_EN
    logic          r_parity_err;
`endif

    logic       w_txd_wr;
    logic       w_con_wr;
    logic       w_rxd_rd;
    logic       w_tx_accept;
    logic       w_tx_last;
    logic [2:0] w_tx_next_bit;
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_perr;
    logic       w_unused;

    assign w_txd_wr      = wr && (addr == UART_TXD_ADDR);
    assign w_con_wr      = wr && (addr == UART_CON_ADDR);
    assign w_rxd_rd      = rd && (addr == UART_RXD_ADDR);
    assign w_tx_accept   = w_txd_wr && !r_tx_busy;
    assign w_tx_last     = (r_tx_cnt == BIT_LAST);
    assign w_tx_next_bit = r_tx_bit + 3'd1;
    assign w_unused      = ^{wdata[31:8], wdata[6], w_rx_perr};

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_rxd        (uart_rxd),
        .o_rx_byte    (w_rx_byte),
        .o_rx_valid   (w_rx_valid),
        .o_parity_err (w_rx_perr)
    );

    // Transmit FSM; the line register changes on the same edge as the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_byte  <= 8'd0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            // Software clear first so a hardware set later in the block wins
            if (w_con_wr && wdata[CON_TX_DONE]) r_tx_done <= 1'b0;
            case (r_tx_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_tx_accept) begin
                        r_tx_byte <= wdata[7:0];
                        r_tx_busy <= 1'b1;
                        r_tx_done <= 1'b0;
                    end else if (r_tx_busy) begin
                        r_tx_state <= ST_START;
                        r_tx_cnt   <= '0;
                        r_txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= ST_DATA;
                        r_txd      <= r_tx_byte[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tx_last) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx_state <= ST_PARITY;
                            r_txd      <= ^r_tx_byte;
`else
                            r_tx_state <= ST_STOP;
                            r_txd      <= 1'b1;
`endif
                        end else begin
                            r_tx_bit <= w_tx_next_bit;
                            r_txd    <= r_tx_byte[w_tx_next_bit];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_STOP;
                        r_txd      <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_IDLE;
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: begin
                    r_tx_state <= ST_IDLE;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

    // Interrupt enables, receive data and receive-side status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_irq_en  <= 1'b0;
            r_rx_irq_en  <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_data    <= 8'd0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_con_wr) begin
                r_tx_irq_en <= wdata[CON_TX_IRQ_EN];
                r_rx_irq_en <= wdata[CON_RX_IRQ_EN];
                if (wdata[CON_RX_OVERRUN]) r_rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
                if (wdata[CON_PARITY_ERR]) r_parity_err <= 1'b0;
`endif
            end
            if (w_rxd_rd) r_rx_ready <= 1'b0;
            // New byte overrides the read clear; a same-edge read consumed the old one
            if (w_rx_valid) begin
                r_rx_data  <= w_rx_byte;
                r_rx_ready <= 1'b1;
                if (r_rx_ready && !w_rxd_rd) r_rx_overrun <= 1'b1;
            end
`ifdef UART_PARITY_EN
            if (w_rx_perr) r_parity_err <= 1'b1;
`endif
        end
    end

    // Combinational read mux; unmapped addresses and idle cycles return 0
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            case (addr)
                UART_TXD_ADDR: rdata = {24'd0, r_tx_byte};
                UART_RXD_ADDR: rdata = {24'd0, r_rx_data};
                UART_CON_ADDR: begin
                    rdata[CON_TX_IRQ_EN]  = r_tx_irq_en;
                    rdata[CON_RX_IRQ_EN]  = r_rx_irq_en;
                    rdata[CON_TX_DONE]    = r_tx_done;
                    rdata[CON_RX_READY]   = r_rx_ready;
                    rdata[CON_TX_BUSY]    = r_tx_busy;
                    rdata[CON_RX_OVERRUN] = r_rx_overrun;
`ifdef UART_PARITY_EN
                    rdata[CON_PARITY_ERR] = r_parity_err;
`endif
                end
                default: rdata = 32'd0;
            endcase
        end
    end

    assign uart_txd = r_txd;
    assign irqout   = (r_tx_done & r_tx_irq_en) | (r_rx_ready & r_rx_irq_en);

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral at 4 clocks per bit: register map
// table, transmit waveform, receive, overrun, false start, framing error,
// parity flag (UART_PARITY_EN builds) and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_peripheral;

    localparam int CPB = 4;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_rxd;
    logic        uart_txd;
    logic        irqout;

    int n_checks;
    int n_fail;

    // op: 0 = bus idle (rd low), 1 = read, 2 = write
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    uart_peripheral #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .irqout   (irqout)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        #1;
        d = rdata;
        tick();
        rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        logic pbit;
        pbit = (^b) ^ bad_par;
        uart_rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) tick();
        end
`ifdef UART_PARITY_EN
        uart_rxd = pbit;
        repeat (CPB) tick();
`endif
        uart_rxd = stop_bit;
        repeat (CPB) tick();
        uart_rxd = 1'b1;
    endtask

    // Poll CON.rx_ready for a bounded number of cycles
    task automatic wait_ready(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seen) begin
                rd = 1'b1; addr = A_CON;
                #1;
                seen = rdata[3];
                rd = 1'b0;
                if (!seen) tick();
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [10:0] tx_bits;
        logic        saw_low;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{2'd1, A_CON,         32'h0,  32'h0};
        vecs[1]  = '{2'd1, A_TXD,         32'h0,  32'h0};
        vecs[2]  = '{2'd1, A_RXD,         32'h0,  32'h0};
        vecs[3]  = '{2'd1, 32'h4000_0024, 32'h0,  32'h0};
        vecs[4]  = '{2'd1, 32'h4000_0014, 32'h0,  32'h0};
        vecs[5]  = '{2'd1, 32'hC000_0020, 32'h0,  32'h0};
        vecs[6]  = '{2'd2, A_CON,         32'h3,  32'h0};
        vecs[7]  = '{2'd1, A_CON,         32'h0,  32'h3};
        vecs[8]  = '{2'd0, A_CON,         32'h0,  32'h0};
        vecs[9]  = '{2'd2, A_CON,         32'h7C, 32'h0};
        vecs[10] = '{2'd1, A_CON,         32'h0,  32'h0};

`ifdef UART_PARITY_EN
        tx_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        tx_bits = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif

        // Reset
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, uart_txd}, 32'd1);
        check("reset_irq", {31'd0, irqout}, 32'd0);
        reset = 1'b1;
        tick();

        // Register map table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].op == 2'd2) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                rd = vecs[i].op[0]; addr = vecs[i].addr;
                #1;
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
                check($sformatf("vec%0d_irq", i), {31'd0, irqout}, 32'd0);
                tick();
                rd = 1'b0;
            end
        end

        // Transmit 0xA5 with tx interrupt enabled; 0x11 written mid-frame
        bus_write(A_CON, 32'h1);
        bus_write(A_TXD, 32'hA5);
        check("tx_idle_at_write", {31'd0, uart_txd}, 32'd1);
        for (int k = 0; k < FRAME_BITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k == 4 && c == 0) begin
                    wr = 1'b1; addr = A_TXD; wdata = 32'h11;
                end
                tick();
                wr = 1'b0; wdata = 32'd0;
                check($sformatf("tx_bit%0d_c%0d", k, c), {31'd0, uart_txd}, {31'd0, tx_bits[k]});
                if (k == 2 && c == 1) begin
                    rd = 1'b1; addr = A_CON;
                    #1;
                    check("tx_busy_mid_frame", {31'd0, rdata[4]}, 32'd1);
                    rd = 1'b0;
                end
                if (k == FRAME_BITS - 1 && c == CPB - 1)
                    check("tx_irq_before_done", {31'd0, irqout}, 32'd0);
            end
        end
        tick();
        check("tx_irq_at_done", {31'd0, irqout}, 32'd1);
        bus_read(A_CON, d);
        check("tx_con_done", d, 32'h05);
        bus_read(A_TXD, d);
        check("tx_txd_readback", d, 32'hA5);
        bus_write(A_CON, 32'h5);
        check("tx_irq_after_w1c", {31'd0, irqout}, 32'd0);
        bus_read(A_CON, d);
        check("tx_con_after_w1c", d, 32'h01);
        saw_low = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            tick();
            if (uart_txd !== 1'b1) saw_low = 1'b1;
        end
        check("tx_no_second_frame", {31'd0, saw_low}, 32'd0);

        // Receive 0x3C with rx interrupt enabled
        bus_write(A_CON, 32'h2);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_ready("rx_ready_3c");
        check("rx_irq_3c", {31'd0, irqout}, 32'd1);
        bus_read(A_CON, d);
        check("rx_con_3c", d, 32'h0A);
        bus_read(A_RXD, d);
        check("rx_data_3c", d, 32'h3C);
        bus_read(A_CON, d);
        check("rx_con_after_read", d, 32'h02);
        check("rx_irq_after_read", {31'd0, irqout}, 32'd0);

        // Two frames without a read: overrun, newest byte kept
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (2) tick();
        send_frame(8'h02, 1'b1, 1'b0);
        repeat (6) tick();
        bus_read(A_CON, d);
        check("ovr_con", d, 32'h2A);
        bus_read(A_RXD, d);
        check("ovr_data", d, 32'h02);
        bus_write(A_CON, 32'h22);
        bus_read(A_CON, d);
        check("ovr_con_cleared", d, 32'h02);

        // One-cycle glitch, then a frame with a low stop bit
        uart_rxd = 1'b0;
        tick();
        uart_rxd = 1'b1;
        repeat (3 * CPB) tick();
        bus_read(A_CON, d);
        check("false_start_con", d, 32'h02);
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (6) tick();
        bus_read(A_CON, d);
        check("framing_con", d, 32'h02);
        bus_read(A_RXD, d);
        check("framing_data_kept", d, 32'h02);
        repeat (2) tick();
        send_frame(8'h96, 1'b1, 1'b0);
        wait_ready("recover_ready");
        bus_read(A_RXD, d);
        check("recover_data", d, 32'h96);

`ifdef UART_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (6) tick();
        bus_read(A_CON, d);
        check("parity_err_con", d, 32'h42);
        bus_read(A_RXD, d);
        check("parity_data_kept", d, 32'h96);
        bus_write(A_CON, 32'h42);
        bus_read(A_CON, d);
        check("parity_err_cleared", d, 32'h02);
`else
        bus_write(A_CON, 32'h42);
        bus_read(A_CON, d);
        check("bit6_ignored", d, 32'h02);
`endif

        // Reset in the middle of a transmit frame
        bus_write(A_TXD, 32'h00);
        repeat (6) tick();
        check("pre_reset_txd_low", {31'd0, uart_txd}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_txd", {31'd0, uart_txd}, 32'd1);
        check("async_reset_irq", {31'd0, irqout}, 32'd0);
        #3;
        reset = 1'b1;
        tick();
        bus_read(A_CON, d);
        check("post_reset_con", d, 32'h00);
        tick();
        check("post_reset_txd", {31'd0, uart_txd}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
